// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and baud constants.
package uart_pkg;

    localparam int unsigned CLOCK_HZ     = 100_000_000;
    localparam int unsigned DEFAULT_BAUD = 9600;
    localparam int unsigned BAUD_DIV     = CLOCK_HZ / DEFAULT_BAUD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Rising-edge detector turning the divider's baud_clk into a one-cycle tick.
module uart_baud_tick (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_baud_clk,
    output logic o_tick_c
);

    logic r_baud_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_baud_q <= 1'b0;
        end else begin
            r_baud_q <= i_baud_clk;
        end
    end

    assign o_tick_c = i_baud_clk & ~r_baud_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-wide UART transmitter, LSB-first, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert one even-parity bit after the data bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS);

    tx_state_t            r_state, w_state_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [CNT_W-1:0]     r_bit_cnt, w_bit_cnt_next;
    logic                 r_stop_cnt, w_stop_cnt_next;
    logic                 r_tx, w_tx_next;
    logic                 r_tx_ready, w_tx_ready_next;
    logic                 r_tx_busy, w_tx_busy_next;
    logic                 w_tick;
`ifdef UART_TX_PARITY_EN
    logic [DATA_BITS-1:0] r_data, w_data_next;
`endif

    uart_baud_tick u_tick (
        .i_clk      (clock_in),
        .i_rst      (reset),
        .i_baud_clk (baud_clk),
        .o_tick_c   (w_tick)
    );

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
            r_tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_data     <= '0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_tx       <= w_tx_next;
            r_tx_ready <= w_tx_ready_next;
            r_tx_busy  <= w_tx_busy_next;
`ifdef UART_TX_PARITY_EN
            r_data     <= w_data_next;
`endif
        end
    end

    // Next state, then outputs decoded from the next state so they register in step.
    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_cnt_next  = r_bit_cnt;
        w_stop_cnt_next = r_stop_cnt;
        w_tx_next       = 1'b1;
        w_tx_ready_next = 1'b0;
        w_tx_busy_next  = 1'b1;
`ifdef UART_TX_PARITY_EN
        w_data_next     = r_data;
`endif

        case (r_state)
            ST_IDLE: begin
                if (tx_valid && r_tx_ready) begin
                    w_shift_next    = tx_data;
                    w_bit_cnt_next  = '0;
                    w_stop_cnt_next = 1'b0;
                    w_state_next    = ST_SYNC;
`ifdef UART_TX_PARITY_EN
                    w_data_next     = tx_data;
`endif
                end
            end
            ST_SYNC: begin
                if (w_tick) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_tick) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_next   = r_shift >> 1;
                    w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                        w_bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next   = ST_PARITY;
`else
                        w_state_next   = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) w_state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                        w_stop_cnt_next = 1'b0;
                        w_state_next    = ST_IDLE;
                    end else begin
                        w_stop_cnt_next = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        case (w_state_next)
            ST_IDLE: begin
                w_tx_ready_next = 1'b1;
                w_tx_busy_next  = 1'b0;
            end
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = ^w_data_next;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

    assign tx       = r_tx;
    assign tx_ready = r_tx_ready;
    assign tx_busy  = r_tx_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: drivers queue expected bytes, a serial-line monitor decodes frames and compares.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Baud clock: period 8 cycles, rises in the cycle where ph == 0.
    int ph = 0;
    always @(posedge clk) ph <= (ph + 1) % 8;
    logic baud_clk;
    assign baud_clk = (ph < 4);

    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       ready0, ready1, busy0, busy1, tx0, tx1;

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1)) dut0 (
        .clock_in(clk), .reset(rst), .baud_clk(baud_clk), .tx_data(data0),
        .tx_valid(valid0), .tx_ready(ready0), .tx_busy(busy0), .tx(tx0)
    );

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2)) dut1 (
        .clock_in(clk), .reset(rst), .baud_clk(baud_clk), .tx_data(data1),
        .tx_valid(valid1), .tx_ready(ready1), .tx_busy(busy1), .tx(tx1)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
        bit         b2b;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic get_tx(input int d);
        return (d == 0) ? tx0 : tx1;
    endfunction

    function automatic logic get_rdy(input int d);
        return (d == 0) ? ready0 : ready1;
    endfunction

    function automatic int flen(input int d);
        return 1 + 8 + PAR + ((d == 0) ? 1 : 2);
    endfunction

    // Monitor state per DUT.
    bit          m_act[2];
    int          m_cyc[2];
    int          m_nb[2];
    logic [15:0] m_bits[2];
    int          m_start[2];
    int          m_last_start[2];
    bit          m_start_ok[2];
    logic        m_prev_rdy[2];
    int          now = 0;

    task automatic finish_frame(input int d);
        exp_t e;
        logic stop_ok;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: dut%0d sent 0x%0h, required no frame", d, m_bits[d][8:1]);
        end else begin
            e = exp_q.pop_front();
            check("frame_dut", 32'(d), 32'(e.id));
            check("start_bit", 32'(m_bits[d][0]), 32'd0);
            check("data", 32'(m_bits[d][8:1]), 32'(e.data));
`ifdef UART_TX_PARITY_EN
            check("parity", 32'(m_bits[d][9]), 32'(^e.data));
`endif
            stop_ok = 1'b1;
            for (int i = 9 + PAR; i < flen(d); i++) stop_ok &= m_bits[d][i];
            check("stop_bits", 32'(stop_ok), 32'd1);
            if (e.b2b) check("b2b_gap", 32'(m_start[d] - m_last_start[d]), 32'((flen(d) + 1) * 8));
        end
    endtask

    always @(negedge clk) begin
        now++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                if (m_act[d] && exp_q.size() > 0) void'(exp_q.pop_front());
                m_act[d]      = 1'b0;
                m_start_ok[d] = 1'b0;
                m_prev_rdy[d] = get_rdy(d);
            end else begin
                if (get_rdy(d) && !m_prev_rdy[d] && m_start_ok[d])
                    check("ready_return", 32'(now - m_start[d]), 32'(flen(d) * 8));
                m_prev_rdy[d] = get_rdy(d);
                if (!m_act[d]) begin
                    if (get_tx(d) == 1'b0) begin
                        m_act[d]        = 1'b1;
                        m_cyc[d]        = 0;
                        m_nb[d]         = 0;
                        m_bits[d]       = '0;
                        check("start_phase", 32'(ph), 32'd1);
                        m_last_start[d] = m_start[d];
                        m_start[d]      = now;
                        m_start_ok[d]   = 1'b1;
                    end
                end else begin
                    m_cyc[d]++;
                    if (m_cyc[d] % 8 == 4) begin
                        m_bits[d][m_nb[d]] = get_tx(d);
                        m_nb[d]++;
                        if (m_nb[d] == flen(d)) begin
                            m_act[d] = 1'b0;
                            finish_frame(d);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int d, input logic [7:0] b, input bit b2b);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        if (d == 0) begin valid0 = 1'b1; data0 = b; end
        else        begin valid1 = 1'b1; data1 = b; end
        while (!get_rdy(d) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: dut%0d ready stayed 0, required 1", d);
        end else begin
            e.id = d; e.data = b; e.b2b = b2b;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (d == 0) valid0 = 1'b0;
        else        valid1 = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || !ready0 || !ready1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: %0d frames outstanding, required 0", exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int bad;
        int n;
        rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0; data0 = '0; data1 = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx0", 32'(tx0), 32'd1);
        check("rst_ready0", 32'(ready0), 32'd1);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_tx1", 32'(tx1), 32'd1);
        check("rst_ready1", 32'(ready1), 32'd1);
        check("rst_busy1", 32'(busy1), 32'd0);

        bad = 0;
        repeat (800) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0 ||
                tx1 !== 1'b1 || ready1 !== 1'b1 || busy1 !== 1'b0) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        send(0, 8'hA5, 1'b0);
        wait_done();
        send(0, 8'h01, 1'b0);
        wait_done();

        send(1, 8'h00, 1'b0);
        send(1, 8'hFF, 1'b1);
        wait_done();

        send(0, 8'h55, 1'b0);
        repeat (30) @(negedge clk);
        check("busy_mid", 32'(busy0), 32'd1);
        check("ready_mid", 32'(ready0), 32'd0);
        valid0 = 1'b1; data0 = 8'h3C;
        @(negedge clk);
        valid0 = 1'b0; data0 = 8'h00;
        wait_done();
        repeat (200) @(negedge clk);

        send(0, 8'h0F, 1'b0);
        n = 0;
        while (tx0 !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_start_seen", 32'(tx0), 32'd0);
        repeat (36) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_tx", 32'(tx0), 32'd1);
        check("abort_ready", 32'(ready0), 32'd1);
        check("abort_busy", 32'(busy0), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send(0, 8'h81, 1'b0);
        wait_done();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
